// File: rtl/i2c_target_mem.sv
// I2C target with an auto-incrementing register memory, attachable to one of several busses.
// Optional SCL clock stretching after ACK bits is enabled by defining I2C_TARGET_CLK_STRETCH_EN.
module i2c_target_mem #(
  parameter int unsigned NUM_I2C_BUSSES = 1,
  parameter int unsigned I2C_ADDR_WIDTH = 7,
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22,
  parameter int unsigned STRETCH_CYCLES = 8,
  localparam int unsigned SEL_W = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1,
  localparam int unsigned PTR_W = $clog2(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SEL_W-1:0]          bus_sel_i,
  input  logic [NUM_I2C_BUSSES-1:0] scl_i,
  input  logic [NUM_I2C_BUSSES-1:0] sda_i,
  output logic [NUM_I2C_BUSSES-1:0] scl_oe_o,
  output logic [NUM_I2C_BUSSES-1:0] sda_oe_o,
  output logic                      busy_o,
  output logic                      wr_stb_o,
  output logic [PTR_W-1:0]          wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      xfer_done_o,
  input  logic [PTR_W-1:0]          dbg_addr_i,
  output logic [I2C_DATA_WIDTH-1:0] dbg_data_o
);

  localparam int unsigned DW    = I2C_DATA_WIDTH;
  localparam int unsigned AW    = I2C_ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(DW);

  if (MEM_DEPTH < 2 || MEM_DEPTH > 256 || (1 << PTR_W) != MEM_DEPTH ||
      AW >= DW || STRETCH_CYCLES == 0) begin : g_bad_param
    $error("i2c_target_mem: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic              scl_sel, sda_sel;
  logic              scl_s1, scl_s2, scl_d;
  logic              sda_s1, sda_s2, sda_d;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [DW-1:0]     wr_byte, rd_byte;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              nack_q, nack_d;
  logic              busy_d, done_d, wr_en;
  logic              addr_match;
  logic [DW-1:0]     mem [MEM_DEPTH];

  always_comb begin
    scl_sel = 1'b1;
    sda_sel = 1'b1;
    for (int unsigned i = 0; i < NUM_I2C_BUSSES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        scl_sel = scl_i[i];
        sda_sel = sda_i[i];
      end
    end
  end

  assign scl_rise   =  scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 &  scl_d;
  assign start_det  =  scl_s2 &  scl_d & sda_d & ~sda_s2;
  assign stop_det   =  scl_s2 &  scl_d & ~sda_d & sda_s2;
  assign wr_byte    = {shift_q[DW-2:0], sda_s2};
  assign rd_byte    = mem[ptr_q];
  assign addr_match = (shift_q[DW-1 -: AW] == TARGET_ADDR);
  assign dbg_data_o = mem[dbg_addr_i];

  always_comb begin
    sda_oe_o = '0;
    for (int unsigned i = 0; i < NUM_I2C_BUSSES; i++) begin
      sda_oe_o[i] = sda_oe_q && (sel_q == SEL_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    nack_d    = nack_q;
    busy_d    = busy_o;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = busy_o;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: ;
        ADDR, PTR, WR_DATA: begin
          if (scl_rise && bit_cnt_q != BIT_FULL) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (state_q == WR_DATA && bit_cnt_q == BIT_FULL - 1'b1) begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == BIT_FULL) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) begin
              if (addr_match) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d  = IGNORE;
                busy_d   = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d    = shift_q[PTR_W-1:0];
              state_d  = PTR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = WR_ACK;
              sda_oe_d = 1'b1;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            if (state_q == ADDR_ACK && shift_q[0]) begin
              state_d  = RD_DATA;
              sda_oe_d = ~rd_byte[DW-1];
              shift_d  = {rd_byte[DW-2:0], 1'b0};
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise && bit_cnt_q != BIT_FULL) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == BIT_FULL) begin
            state_d   = RD_ACK;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end else if (scl_fall && bit_cnt_q != '0) begin
            // shift_q holds the remaining transmit bits, MSB next
            sda_oe_d = ~shift_q[DW-1];
            shift_d  = {shift_q[DW-2:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_s2;
            ptr_d  = ptr_q + 1'b1;
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d = IGNORE;
            end else begin
              state_d  = RD_DATA;
              sda_oe_d = ~rd_byte[DW-1];
              shift_d  = {rd_byte[DW-2:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_q       <= '0;
      scl_s1      <= 1'b1;
      scl_s2      <= 1'b1;
      scl_d       <= 1'b1;
      sda_s1      <= 1'b1;
      sda_s2      <= 1'b1;
      sda_d       <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      nack_q      <= 1'b0;
      busy_o      <= 1'b0;
      xfer_done_o <= 1'b0;
      wr_stb_o    <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
    end else begin
      if (state_q == IDLE) sel_q <= bus_sel_i;
      scl_s1      <= scl_sel;
      scl_s2      <= scl_s1;
      scl_d       <= scl_s2;
      sda_s1      <= sda_sel;
      sda_s2      <= sda_s1;
      sda_d       <= sda_s2;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      nack_q      <= nack_d;
      busy_o      <= busy_d;
      xfer_done_o <= done_d;
      wr_stb_o    <= wr_en;
      if (wr_en) begin
        wr_addr_o <= ptr_q;
        wr_data_o <= wr_byte;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ptr_q] <= wr_byte;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  localparam int unsigned SC_W = $clog2(STRETCH_CYCLES + 1);
  logic            stretch_go;
  logic [SC_W-1:0] stretch_cnt;

  // Stretch on the SCL fall that closes an ACK bit, except after a master NACK
  assign stretch_go = scl_fall && !start_det && !stop_det &&
                      ((state_q inside {ADDR_ACK, PTR_ACK, WR_ACK}) ||
                       (state_q == RD_ACK && !nack_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 stretch_cnt <= '0;
    else if (stretch_go)        stretch_cnt <= SC_W'(STRETCH_CYCLES);
    else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
  end

  always_comb begin
    scl_oe_o = '0;
    for (int unsigned i = 0; i < NUM_I2C_BUSSES; i++) begin
      scl_oe_o[i] = (stretch_cnt != '0) && (sel_q == SEL_W'(i));
    end
  end
`else
  assign scl_oe_o = '0;
`endif

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: open-drain bus master model on four busses with a write/read scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_mem;

  localparam int NB = 4;
  localparam int Q  = 10;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [1:0]    bus_sel = '0;
  logic [NB-1:0] m_scl = '1;
  logic [NB-1:0] m_sda = '1;
  logic [NB-1:0] scl_line, sda_line;
  logic [NB-1:0] scl_oe_o, sda_oe_o;
  logic          busy_o, wr_stb_o, xfer_done_o;
  logic [3:0]    wr_addr_o, dbg_addr;
  logic [7:0]    wr_data_o, dbg_data_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_done = 0;
  int            exp_done = 0;
  int            bus = 0;
  logic [NB-1:0] oe_seen;
  logic [7:0]    mem_m [16];
  logic [3:0]    ptr_m;
  logic [11:0]   exp_wr [$];
  logic [7:0]    exp_rd [$];
  logic [11:0]   exp_w;

  assign scl_line = m_scl & ~scl_oe_o;
  assign sda_line = m_sda & ~sda_oe_o;

  always #5 clk = ~clk;

  i2c_target_mem #(
    .NUM_I2C_BUSSES(NB),
    .MEM_DEPTH(16),
    .TARGET_ADDR(7'h22)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus_sel_i(bus_sel),
    .scl_i(scl_line),
    .sda_i(sda_line),
    .scl_oe_o(scl_oe_o),
    .sda_oe_o(sda_oe_o),
    .busy_o(busy_o),
    .wr_stb_o(wr_stb_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .xfer_done_o(xfer_done_o),
    .dbg_addr_i(dbg_addr),
    .dbg_data_o(dbg_data_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i && wr_stb_o) begin
      if (exp_wr.size() == 0) begin
        check_val("wr_stb_unexpected", 32'(wr_stb_o), 32'd0);
      end else begin
        exp_w = exp_wr.pop_front();
        check_val("wr_addr_data", 32'({wr_addr_o, wr_data_o}), 32'(exp_w));
      end
    end
    if (xfer_done_o) n_done++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    int n;
    m_sda[bus] = b;
    wait_q();
    m_scl[bus] = 1'b1;
    n = 0;
    while (scl_line[bus] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_val("scl_release_timeout", 32'(scl_line[bus]), 32'd1);
    wait_q();
    r = sda_line[bus];
    oe_seen = sda_oe_o;
    wait_q();
    m_scl[bus] = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda[bus] = 1'b1;
    wait_q();
    m_scl[bus] = 1'b1;
    wait_q();
    m_sda[bus] = 1'b0;
    wait_q();
    m_scl[bus] = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda[bus] = 1'b0;
    wait_q();
    m_scl[bus] = 1'b1;
    wait_q();
    m_sda[bus] = 1'b1;
    wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, r);
      d = {d[6:0], r};
    end
    i2c_bit(nack, r);
  endtask

  task automatic send_addr(input logic [7:0] a, input logic exp_ack);
    logic ack;
    wr_byte(a, ack);
    check_val($sformatf("addr_ack_%02h", a), 32'(ack), 32'(exp_ack));
  endtask

  task automatic send_ptr(input logic [7:0] p);
    logic ack;
    ptr_m = p[3:0];
    wr_byte(p, ack);
    check_val("ptr_ack", 32'(ack), 32'd1);
  endtask

  task automatic send_data(input logic [7:0] d);
    logic ack;
    exp_wr.push_back({ptr_m, d});
    mem_m[ptr_m] = d;
    ptr_m = ptr_m + 4'd1;
    wr_byte(d, ack);
    check_val("data_ack", 32'(ack), 32'd1);
  endtask

  task automatic read_data(input logic nack);
    logic [7:0] d, e;
    exp_rd.push_back(mem_m[ptr_m]);
    ptr_m = ptr_m + 4'd1;
    rd_byte(nack, d);
    e = exp_rd.pop_front();
    check_val("rd_data", 32'(d), 32'(e));
  endtask

  task automatic dbg_check(input logic [3:0] a);
    dbg_addr = a;
    #1;
    check_val($sformatf("dbg_mem_%0d", a), 32'(dbg_data_o), 32'(mem_m[a]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack;
    logic [7:0] d;
    logic r;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    ptr_m = '0;
    dbg_addr = 4'd3;
    repeat (4) @(negedge clk);
    check_val("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    check_val("rst_scl_oe", 32'(scl_oe_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_wr_stb", 32'(wr_stb_o), 32'd0);
    check_val("rst_done", 32'(xfer_done_o), 32'd0);
    check_val("rst_wr_addr_data", 32'({wr_addr_o, wr_data_o}), 32'd0);
    dbg_check(4'd3);
    rst_i = 1'b1;
    repeat (4) @(negedge clk);

    // basic write, ptr 3
    i2c_start();
    send_addr(8'h44, 1'b1);
    check_val("busy_after_ack", 32'(busy_o), 32'd1);
    send_ptr(8'h03);
    send_data(8'hA5);
    send_data(8'h5A);
    i2c_stop();
    exp_done++;
    repeat (8) @(negedge clk);
    check_val("done_cnt_wr", 32'(n_done), 32'(exp_done));
    check_val("busy_after_stop", 32'(busy_o), 32'd0);
    dbg_check(4'd3);
    dbg_check(4'd4);

    // pointer wrap 15 -> 0
    i2c_start();
    send_addr(8'h44, 1'b1);
    send_ptr(8'h0F);
    send_data(8'h11);
    send_data(8'h22);
    i2c_stop();
    exp_done++;
    repeat (8) @(negedge clk);
    dbg_check(4'd15);
    dbg_check(4'd0);

    // pointer set, repeated start, read ACK then NACK
    i2c_start();
    send_addr(8'h44, 1'b1);
    send_ptr(8'h03);
    i2c_start();
    send_addr(8'h45, 1'b1);
    read_data(1'b0);
    read_data(1'b1);
    rd_byte(1'b1, d);
    check_val("ignore_rd_ff", 32'(d), 32'hFF);
    check_val("ignore_sda_oe", 32'(oe_seen), 32'd0);
    check_val("ignore_busy", 32'(busy_o), 32'd1);
    i2c_stop();
    exp_done++;

    // read continues after the NACK increment
    i2c_start();
    send_addr(8'h45, 1'b1);
    read_data(1'b1);
    i2c_stop();
    exp_done++;
    repeat (8) @(negedge clk);
    check_val("done_cnt_rd", 32'(n_done), 32'(exp_done));

    // wrong address: no ACK, no write, no done pulse
    i2c_start();
    send_addr(8'h46, 1'b0);
    check_val("busy_mismatch", 32'(busy_o), 32'd0);
    wr_byte(8'h99, ack);
    check_val("mismatch_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    repeat (8) @(negedge clk);
    check_val("done_cnt_mismatch", 32'(n_done), 32'(exp_done));

    // bus 2 selected, traffic on bus 2
    bus_sel = 2'd2;
    repeat (4) @(negedge clk);
    bus = 2;
    i2c_start();
    send_addr(8'h44, 1'b1);
    check_val("bus2_ack_oe", 32'(oe_seen), 32'h4);
    send_ptr(8'h07);
    send_data(8'h3C);
    i2c_stop();
    exp_done++;
    repeat (8) @(negedge clk);
    dbg_check(4'd7);

    // same traffic on bus 1 while bus 2 is selected
    bus = 1;
    i2c_start();
    send_addr(8'h44, 1'b0);
    check_val("bus1_ack_oe", 32'(oe_seen), 32'd0);
    i2c_stop();
    repeat (8) @(negedge clk);
    check_val("done_cnt_bus", 32'(n_done), 32'(exp_done));
    check_val("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    // reset while the target drives a 0 data bit (mem[8] is 0)
    bus = 2;
    i2c_start();
    send_addr(8'h45, 1'b1);
    m_sda[bus] = 1'b1;
    wait_q();
    m_scl[bus] = 1'b1;
    wait_q();
    check_val("rd_drive_zero", 32'(sda_oe_o), 32'h4);
    rst_i = 1'b0;
    #1;
    check_val("midrst_sda_oe", 32'(sda_oe_o), 32'd0);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    dbg_check(4'd3);
    dbg_check(4'd7);
    m_scl = '1;
    m_sda = '1;
    i2c_bit(1'b1, r);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_mem.md
Name: i2c_target_mem

Overview:
- Synthesizable I2C target (slave) with an internal register memory, attachable to any of NUM_I2C_BUSSES busses of the multi-bus controller.
- Oversamples SCL/SDA on the system clock and decodes start, stop, address, pointer and data phases.
- ACKs its own address and serves auto-incrementing reads and writes.
- Replaces the purely behavioural responder in benches and gives hardware-in-loop targets for multi-bus regressions.

Parameters:
NUM_I2C_BUSSES, 1, number of I2C busses on the scl/sda vectors
I2C_ADDR_WIDTH, 7, target address width
I2C_DATA_WIDTH, 8, data byte width; also the pointer byte width
MEM_DEPTH, 16, register memory depth (power of 2, 2..256)
TARGET_ADDR, 7'h22, address this target answers
STRETCH_CYCLES, 8, clk_i cycles SCL is held low per stretch (optional feature only)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
bus_sel_i  in  $clog2(NUM_I2C_BUSSES) (min 1)  index of the bus the target listens on; sampled only in IDLE
scl_i  in  NUM_I2C_BUSSES  I2C clock inputs
sda_i  in  NUM_I2C_BUSSES  I2C data inputs
scl_oe_o  out  NUM_I2C_BUSSES  1 = pull SCL low (open drain)
sda_oe_o  out  NUM_I2C_BUSSES  1 = pull SDA low (open drain)
busy_o  out  1  high from the accepted address ACK to stop
wr_stb_o  out  1  one-cycle pulse per byte written to memory
wr_addr_o  out  $clog2(MEM_DEPTH)  memory address of the write
wr_data_o  out  I2C_DATA_WIDTH  data written
xfer_done_o  out  1  one-cycle pulse on stop when busy_o was high
dbg_addr_i  in  $clog2(MEM_DEPTH)  backdoor read address
dbg_data_o  out  I2C_DATA_WIDTH  combinational mem[dbg_addr_i]

Behaviour:
- Reset (rst_i low, asynchronous): all outputs 0; memory, pointer and bit counter cleared; FSM goes to IDLE. Asserting reset mid-transfer releases SDA/SCL in the same instant.
- Selected bus scl/sda pass through a 2-flop synchronizer plus a 1-cycle history register; edges are detected on the synchronized values. Latency from pin to decision is 3 clk_i cycles.
- Only the bit at index bus_sel (latched in IDLE) of either oe output may be asserted; all other bits stay 0.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state.
  - START from any state goes to ADDR and clears the bit counter (this covers repeated start).
  - STOP from any state goes to IDLE and pulses xfer_done_o if busy_o was high.
- Bits are MSB first. SDA is sampled on SCL rise; sda_oe changes on SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: shifts in 8 bits.
  - Address match: go to ADDR_ACK and drive SDA low from the 8th SCL fall to the 9th SCL fall. Then go to PTR if R/W=0, or RD_DATA if R/W=1.
  - Mismatch: go to IGNORE with no ACK.
- PTR: byte is loaded into the pointer mod MEM_DEPTH, ACKed, then go to WR_DATA.
- WR_DATA: each byte is written to mem[ptr] on the 8th SCL rise. wr_stb_o, wr_addr_o and wr_data_o are valid that cycle. The byte is ACKed and ptr increments, wrapping MEM_DEPTH-1 to 0.
- RD_DATA: drives ~mem[ptr][bit] (open drain) from the SCL fall that ends the ACK. After 8 bits SDA is released and RD_ACK samples the master.
  - Master ACK (0): ptr++ with wrap, next byte.
  - Master NACK (1): go to IGNORE, ptr still increments.
- IGNORE: drives nothing until START or STOP.
- busy_o is set on ADDR_ACK entry and cleared on STOP or reset. A repeated start to a different address clears it.

Optional Feature:
- Macro: I2C_TARGET_CLK_STRETCH_EN
- Defined: on every SCL fall that ends an ACK bit (ADDR_ACK, PTR_ACK, WR_ACK, and RD_ACK with master ACK), scl_oe is held high for STRETCH_CYCLES clk_i cycles, then released. The FSM advances only after SCL is seen high again.
- Undefined: scl_oe_o is tied to 0.

Test Plan:
- Reset mid-read (rst_i low while driving a 0 bit) -> sda_oe_o=0 within the same cycle; busy_o=0; mem reads 0 via dbg.
- START, 0x44 (0x22+W), ptr 0x03, data 0xA5, 0x5A, STOP -> three ACKs; wr_stb_o twice at addr 3 then 4; dbg mem[3]=0xA5, mem[4]=0x5A; one xfer_done_o pulse.
- Write ptr 0x0F with data 0x11, 0x22 (MEM_DEPTH=16) -> mem[15]=0x11, mem[0]=0x22 (wrap).
- Write ptr 0x03, repeated START, 0x45, read 2 bytes (ACK then NACK), STOP -> master sees 0xA5 then 0x5A; FSM in IGNORE before STOP.
- START, 0x46 (address 0x23) -> no ACK (SDA high on 9th clock); busy_o stays 0; no wr_stb_o.
- NUM_I2C_BUSSES=4, bus_sel_i=2, traffic on bus 2 -> only bit 2 of sda_oe_o asserts. Same traffic on bus 1 -> no response.
